// File: rtl/icache_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The state values keep the existing 3-bit IFU_IDLE..IFU_DRAIN encoding.
package icache_fetch_unit_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLookup = 3'd1,
      StFill   = 3'd2,
      StWait   = 3'd3,
      StWrite  = 3'd4,
      StDrain  = 3'd5
   } ifu_state_e;

   localparam logic [1:0] LastByte = 2'd3;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/icache_fetch_unit_if.sv
// Fetch, cache-port and memory-arbiter signals of the fetch unit.
// The master modport is the fetch unit's view; the slave modport is its environment.
interface icache_fetch_unit_if;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_flush;
   logic        inst_valid;
   logic [31:0] inst;

   logic        cache_valid;
   logic        cache_wr;
   logic [31:0] cache_addr;
   logic [31:0] cache_wdata;
   logic        cache_hit;
   logic [31:0] cache_rdata;

   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_grant;
   logic        mem_rvalid;
   logic [7:0]  mem_rdata;

   modport master (
      input  fetch_valid, fetch_addr, fetch_flush,
      output fetch_ready, inst_valid, inst,
      output cache_valid, cache_wr, cache_addr, cache_wdata,
      input  cache_hit, cache_rdata,
      output mem_req, mem_addr,
      input  mem_grant, mem_rvalid, mem_rdata
   );

   modport slave (
      output fetch_valid, fetch_addr, fetch_flush,
      input  fetch_ready, inst_valid, inst,
      input  cache_valid, cache_wr, cache_addr, cache_wdata,
      output cache_hit, cache_rdata,
      input  mem_req, mem_addr,
      output mem_grant, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/icache_fetch_unit.sv
// Instruction-fetch front end: probes the direct-mapped cache, refills a missing
// word byte-serially from main memory and returns the fetched instruction.
module icache_fetch_unit
   import icache_fetch_unit_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   icache_fetch_unit_if.master bus
);

   ifu_state_e  state_q;
   logic [31:0] pc_q;
   logic [1:0]  cnt_q;
   logic [23:0] buf_q;
   logic [31:0] inst_q;
   logic        inst_valid_q;

   // Control outputs are decoded from state only.
   assign bus.fetch_ready = (state_q == StIdle);
   assign bus.cache_valid = (state_q == StLookup) || (state_q == StWrite);
   assign bus.cache_wr    = (state_q == StWrite);
   assign bus.cache_addr  = pc_q;
   assign bus.cache_wdata = inst_q;
   // A flush withdraws the request in the same cycle, unless the FSM is frozen.
   assign bus.mem_req     = (state_q == StFill) && !(bus.fetch_flush && rdy);
   assign bus.mem_addr    = pc_q + {30'd0, cnt_q};
   assign bus.inst        = inst_q;
   assign bus.inst_valid  = inst_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         pc_q         <= 32'd0;
         cnt_q        <= 2'd0;
         buf_q        <= 24'd0;
         inst_q       <= 32'd0;
         inst_valid_q <= 1'b0;
      end else if (rdy) begin
         inst_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.fetch_valid) begin
                  pc_q    <= word_align(bus.fetch_addr);
                  cnt_q   <= 2'd0;
                  state_q <= StLookup;
               end
            end
            StLookup: begin
               if (bus.fetch_flush) begin
                  state_q <= StIdle;
               end else if (bus.cache_hit) begin
                  inst_q       <= bus.cache_rdata;
                  inst_valid_q <= 1'b1;
                  state_q      <= StIdle;
               end else begin
                  cnt_q   <= 2'd0;
                  state_q <= StFill;
               end
            end
            StFill: begin
               if (bus.fetch_flush) begin
                  state_q <= StIdle;
               end else if (bus.mem_grant) begin
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (bus.mem_rvalid) begin
                  if (bus.fetch_flush) begin
                     state_q <= StIdle;
                  end else if (cnt_q != LastByte) begin
                     buf_q[{cnt_q, 3'b000} +: 8] <= bus.mem_rdata;
                     cnt_q                       <= cnt_q + 2'd1;
                     state_q                     <= StFill;
                  end else begin
                     inst_q       <= {bus.mem_rdata, buf_q};
                     inst_valid_q <= 1'b1;
                     state_q      <= StWrite;
                  end
               end else if (bus.fetch_flush) begin
                  state_q <= StDrain;
               end
            end
            // The refilled word is correct for pc, so a flush here still lets it land.
            StWrite: begin
               state_q <= StIdle;
            end
            StDrain: begin
               if (bus.mem_rvalid) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
